// File: rtl/fifo_param_if.sv
// fifo_param_if: handshake, data and status bundle between a FIFO user and fifo_param.
//   master : drives wr_en, rd_en, din; observes dout, data_count, flags, acks/errs, state
//   slave  : the FIFO side, with the directions reversed
`timescale 1ns/1ps
interface fifo_param_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic [ADDR_WIDTH:0]   data_count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [2:0]            state;

   modport master (
      output wr_en, rd_en, din,
      input  dout, data_count, full, empty, almost_full, almost_empty,
             wr_ack, wr_err, rd_ack, rd_err, state
   );

   modport slave (
      input  wr_en, rd_en, din,
      output dout, data_count, full, empty, almost_full, almost_empty,
             wr_ack, wr_err, rd_ack, rd_err, state
   );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with simultaneous read/write, registered
// status flags, registered acks/errors and a registered operation-state machine.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : fifo_param_if.slave (wr_en, rd_en, din in; dout, data_count, full, empty,
//             almost_full, almost_empty, wr_ack, wr_err, rd_ack, rd_err, state out)
// Build option: define FIFO_PARAM_STICKY_ERR_EN to make wr_err/rd_err sticky until the
// next accepted write/read; otherwise they are one-cycle pulses.
`timescale 1ns/1ps
module fifo_param #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned AF_LEVEL   = 28,
   parameter int unsigned AE_LEVEL   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   fifo_param_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      WRITE     = 3'b001,
      READ      = 3'b010,
      WR_ERROR  = 3'b011,
      RD_ERROR  = 3'b100,
      WR_RD     = 3'b101,
      WR_ERR_RD = 3'b110,
      RD_ERR_WR = 3'b111
   } state_t;

   state_t                state_q, state_nx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q, count_nx;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  full_q, empty_q, af_q, ae_q;
   logic                  wr_ack_q, rd_ack_q, wr_err_q, rd_err_q;
   logic                  do_wr, do_rd, is_full, is_empty;
   logic                  wr_ack_nx, rd_ack_nx, wr_err_nx, rd_err_nx;

   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);

   // Next state, accepted operations and ack/err decode of the next state
   always_comb begin
      state_nx = IDLE;
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      case ({bus.wr_en, bus.rd_en})
         2'b10: begin
            if (!is_full) begin
               state_nx = WRITE;
               do_wr    = 1'b1;
            end else begin
               state_nx = WR_ERROR;
            end
         end
         2'b01: begin
            if (!is_empty) begin
               state_nx = READ;
               do_rd    = 1'b1;
            end else begin
               state_nx = RD_ERROR;
            end
         end
         2'b11: begin
            // At a boundary only the operation that keeps occupancy in range proceeds
            if (is_full) begin
               state_nx = WR_ERR_RD;
               do_rd    = 1'b1;
            end else if (is_empty) begin
               state_nx = RD_ERR_WR;
               do_wr    = 1'b1;
            end else begin
               state_nx = WR_RD;
               do_wr    = 1'b1;
               do_rd    = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      count_nx  = count_q + CW'(do_wr) - CW'(do_rd);
      wr_ack_nx = state_nx inside {WRITE, WR_RD, RD_ERR_WR};
      rd_ack_nx = state_nx inside {READ, WR_RD, WR_ERR_RD};
      wr_err_nx = state_nx inside {WR_ERROR, WR_ERR_RD};
      rd_err_nx = state_nx inside {RD_ERROR, RD_ERR_WR};
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_nx;
   end

   // Pointers, occupancy, read data and registered status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         wr_ack_q <= 1'b0;
         rd_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            dout_q   <= mem[rd_ptr_q];
         end
         count_q  <= count_nx;
         full_q   <= (count_nx == CW'(DEPTH));
         empty_q  <= (count_nx == '0);
         af_q     <= (count_nx >= CW'(AF_LEVEL));
         ae_q     <= (count_nx <= CW'(AE_LEVEL));
         wr_ack_q <= wr_ack_nx;
         rd_ack_q <= rd_ack_nx;
`ifdef FIFO_PARAM_STICKY_ERR_EN
         // Error held from a rejection until the next accepted operation of that kind
         wr_err_q <= wr_err_nx | (wr_err_q & ~wr_ack_nx);
         rd_err_q <= rd_err_nx | (rd_err_q & ~rd_ack_nx);
`else
         wr_err_q <= wr_err_nx;
         rd_err_q <= rd_err_nx;
`endif
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q] <= bus.din;
   end

   assign bus.state        = state_q;
   assign bus.dout         = dout_q;
   assign bus.data_count   = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.wr_ack       = wr_ack_q;
   assign bus.rd_ack       = rd_ack_q;
   assign bus.wr_err       = wr_err_q;
   assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param with a queue-based reference model
// compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_fifo_param;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int          DEPTH = 32;
   localparam int          AF    = 28;
   localparam int          AE    = 4;
`ifdef FIFO_PARAM_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   n_chk = 0;
   int   n_err = 0;
   bit   chk_on = 0;

   fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: contents as a queue, outcomes from occupancy rules
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   logic [2:0]    m_state;
   logic          m_wr_ack, m_rd_ack, m_wr_err, m_rd_err;
   int            m_count;
   int            n;
   bit            wok, rok;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_dout   = '0;
         m_state  = 3'd0;
         m_wr_ack = 1'b0;
         m_rd_ack = 1'b0;
         m_wr_err = 1'b0;
         m_rd_err = 1'b0;
         m_count  = 0;
      end else begin
         n   = q.size();
         wok = bus.wr_en && (n < DEPTH);
         rok = bus.rd_en && (n > 0);
         if (rok) m_dout = q.pop_front();
         if (wok) q.push_back(bus.din);
         if (!bus.wr_en && !bus.rd_en)      m_state = 3'd0;
         else if (bus.wr_en && !bus.rd_en)  m_state = wok ? 3'd1 : 3'd3;
         else if (!bus.wr_en && bus.rd_en)  m_state = rok ? 3'd2 : 3'd4;
         else if (n == DEPTH)               m_state = 3'd6;
         else if (n == 0)                   m_state = 3'd7;
         else                               m_state = 3'd5;
         m_wr_ack = wok;
         m_rd_ack = rok;
         if (STICKY) begin
            m_wr_err = (bus.wr_en && !wok) ? 1'b1 : (wok ? 1'b0 : m_wr_err);
            m_rd_err = (bus.rd_en && !rok) ? 1'b1 : (rok ? 1'b0 : m_rd_err);
         end else begin
            m_wr_err = bus.wr_en && !wok;
            m_rd_err = bus.rd_en && !rok;
         end
         m_count = q.size();
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("dout",         64'(bus.dout),         64'(m_dout));
         chk("data_count",   64'(bus.data_count),   64'(m_count));
         chk("state",        64'(bus.state),        64'(m_state));
         chk("full",         64'(bus.full),         64'(m_count == DEPTH));
         chk("empty",        64'(bus.empty),        64'(m_count == 0));
         chk("almost_full",  64'(bus.almost_full),  64'(m_count >= AF));
         chk("almost_empty", 64'(bus.almost_empty), 64'(m_count <= AE));
         chk("wr_ack",       64'(bus.wr_ack),       64'(m_wr_ack));
         chk("rd_ack",       64'(bus.rd_ack),       64'(m_rd_ack));
         chk("wr_err",       64'(bus.wr_err),       64'(m_wr_err));
         chk("rd_err",       64'(bus.rd_err),       64'(m_rd_err));
      end
   end

   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      bus.din   = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
      #1;
      chk_on = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-stream with ten words stored
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i + 50));
      chk("pre_reset_count", 64'(bus.data_count), 64'd10);
      bus.wr_en = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk("rst_count", 64'(bus.data_count),   64'd0);
      chk("rst_empty", 64'(bus.empty),        64'd1);
      chk("rst_ae",    64'(bus.almost_empty), 64'd1);
      chk("rst_dout",  64'(bus.dout),         64'd0);
      chk("rst_state", 64'(bus.state),        64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Fill 0..31, then overflow
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b0, DW'(i));
         chk("fill_ack",   64'(bus.wr_ack),     64'd1);
         chk("fill_count", 64'(bus.data_count), 64'(i + 1));
         if (i == 26) chk("fill_af_below", 64'(bus.almost_full), 64'd0);
         if (i == 27) chk("fill_af_at28",  64'(bus.almost_full), 64'd1);
      end
      chk("fill_full", 64'(bus.full), 64'd1);
      step(1'b1, 1'b0, DW'(999));
      chk("ovf_err",   64'(bus.wr_err),     64'd1);
      chk("ovf_state", 64'(bus.state),      64'd3);
      chk("ovf_count", 64'(bus.data_count), 64'd32);

      // Drain in order, then underflow
      for (int k = 1; k <= 32; k++) begin
         step(1'b0, 1'b1, '0);
         chk("drain_dout",  64'(bus.dout),       64'(k - 1));
         chk("drain_ack",   64'(bus.rd_ack),     64'd1);
         chk("drain_count", 64'(bus.data_count), 64'(32 - k));
         if (k == 27) chk("drain_ae_above", 64'(bus.almost_empty), 64'd0);
         if (k == 28) chk("drain_ae_at4",   64'(bus.almost_empty), 64'd1);
      end
      chk("drain_empty", 64'(bus.empty), 64'd1);
      step(1'b0, 1'b1, '0);
      chk("udf_err",   64'(bus.rd_err), 64'd1);
      chk("udf_state", 64'(bus.state),  64'd4);
      chk("udf_dout",  64'(bus.dout),   64'd31);

      // Simultaneous read/write at count 5, pointers wrap
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(100 + i));
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, DW'(200 + i));
         chk("sim_state", 64'(bus.state),      64'd5);
         chk("sim_count", 64'(bus.data_count), 64'd5);
         chk("sim_dout",  64'(bus.dout),       (i < 5) ? 64'(100 + i) : 64'(200 + i - 5));
      end

      // Both requests while empty, then while full
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, DW'(77));
      chk("e_both_state", 64'(bus.state),      64'd7);
      chk("e_both_wack",  64'(bus.wr_ack),     64'd1);
      chk("e_both_rerr",  64'(bus.rd_err),     64'd1);
      chk("e_both_count", 64'(bus.data_count), 64'd1);
      for (int i = 0; i < 31; i++) step(1'b1, 1'b0, DW'(300 + i));
      step(1'b1, 1'b1, DW'(555));
      chk("f_both_state", 64'(bus.state),      64'd6);
      chk("f_both_rack",  64'(bus.rd_ack),     64'd1);
      chk("f_both_werr",  64'(bus.wr_err),     64'd1);
      chk("f_both_count", 64'(bus.data_count), 64'd31);
      chk("f_both_dout",  64'(bus.dout),       64'd77);

      // Error persistence after an overflow
      step(1'b1, 1'b0, DW'(1));
      step(1'b1, 1'b0, DW'(2));
      chk("st_ovf", 64'(bus.wr_err), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, '0);
         chk("st_idle_werr", 64'(bus.wr_err), 64'(STICKY));
      end
      step(1'b0, 1'b1, '0);
      chk("st_read_werr", 64'(bus.wr_err), 64'(STICKY));
      step(1'b1, 1'b0, DW'(3));
      chk("st_write_ack",  64'(bus.wr_ack), 64'd1);
      chk("st_write_werr", 64'(bus.wr_err), 64'd0);

      step(1'b0, 1'b0, '0);
      @(negedge clk);
      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
